// File: rtl/sram_rw_init_ext.sv
// Single-port SRAM behavioural model with write masking, an optional output
// register stage, a read-valid strobe and a clear sequencer that writes
// INIT_VAL to every word after reset or on init_req.
//
// Ports:
//   RW0_clk     clock; all state updates on the rising edge
//   RW0_rst_n   asynchronous active-low reset
//   RW0_addr    word address
//   RW0_en      access request (ignored while clearing)
//   RW0_wmode   1 = write, 0 = read
//   RW0_wdata   write data
//   RW0_wmask   per-lane write enable, lane i = bits [i*MASK_GRAN +: MASK_GRAN]
//   RW0_rdata   read data, held until the next accepted read
//   RW0_rvalid  one-cycle strobe marking new RW0_rdata
//   RW0_ready   high when accesses are accepted (sequencer idle)
//   init_req    request a full re-clear
module sram_rw_init_ext #(
   parameter int unsigned     DEPTH     = 1024,
   parameter int unsigned     WIDTH     = 32,
   parameter int unsigned     MASK_GRAN = 8,
   parameter int unsigned     OUT_REG   = 0,
   parameter logic [WIDTH-1:0] INIT_VAL = '0,
   localparam int unsigned    AW        = $clog2(DEPTH),
   localparam int unsigned    MW        = WIDTH / MASK_GRAN
) (
   input  logic             RW0_clk,
   input  logic             RW0_rst_n,
   input  logic [AW-1:0]    RW0_addr,
   input  logic             RW0_en,
   input  logic             RW0_wmode,
   input  logic [WIDTH-1:0] RW0_wdata,
   input  logic [MW-1:0]    RW0_wmask,
   output logic [WIDTH-1:0] RW0_rdata,
   output logic             RW0_rvalid,
   output logic             RW0_ready,
   input  logic             init_req
);

   typedef enum logic [0:0] {StClear, StIdle} state_e;

   state_e           state;
   logic [AW-1:0]    cnt;
   logic             ready_q;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic [WIDTH-1:0] ram [DEPTH];

   logic acc_wr;
   logic acc_rd;

   assign acc_wr = (state == StIdle) && RW0_en && RW0_wmode;
   assign acc_rd = (state == StIdle) && RW0_en && !RW0_wmode;

   // Array storage has no reset; the clear sequencer provides the known state.
   always_ff @(posedge RW0_clk) begin
      if (state == StClear) begin
         ram[cnt] <= INIT_VAL;
      end else if (acc_wr) begin
         for (int unsigned i = 0; i < MW; i++) begin
            if (RW0_wmask[i]) begin
               ram[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

   always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
         state    <= StClear;
         cnt      <= '0;
         ready_q  <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= acc_rd;
         if (acc_rd) begin
            rd_data <= ram[RW0_addr];
         end
         unique case (state)
            StClear: begin
               cnt <= cnt + AW'(1);
               if (cnt == AW'(DEPTH - 1)) begin
                  state   <= StIdle;
                  ready_q <= 1'b1;
               end
            end
            StIdle: begin
               // An access in the same cycle still completes; clearing starts next edge.
               if (init_req) begin
                  state   <= StClear;
                  cnt     <= '0;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state   <= StClear;
               cnt     <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign RW0_ready = ready_q;

   if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] out_data;
      logic             out_valid;

      always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
         if (!RW0_rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
         end else begin
            out_valid <= rd_valid;
            if (rd_valid) begin
               out_data <= rd_data;
            end
         end
      end

      assign RW0_rdata  = out_data;
      assign RW0_rvalid = out_valid;
   end else begin : g_no_out_reg
      assign RW0_rdata  = rd_data;
      assign RW0_rvalid = rd_valid;
   end

endmodule

// File: tb/tb_sram_rw_init_ext.sv
module tb_sram_rw_init_ext;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] INIT  = 32'hA5A5_A5A5;

   logic        clk;
   logic        rst_n;
   logic [3:0]  addr;
   logic        en;
   logic        wmode;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        init_req;

   logic [31:0] rdata0, rdata1;
   logic        rvalid0, rvalid1, ready0, ready1;

   sram_rw_init_ext #(
      .DEPTH(DEPTH), .WIDTH(32), .MASK_GRAN(8), .OUT_REG(0), .INIT_VAL(INIT)
   ) u_dut0 (
      .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
      .RW0_wmode(wmode), .RW0_wdata(wdata), .RW0_wmask(wmask),
      .RW0_rdata(rdata0), .RW0_rvalid(rvalid0), .RW0_ready(ready0),
      .init_req(init_req)
   );

   sram_rw_init_ext #(
      .DEPTH(DEPTH), .WIDTH(32), .MASK_GRAN(8), .OUT_REG(1), .INIT_VAL(INIT)
   ) u_dut1 (
      .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
      .RW0_wmode(wmode), .RW0_wdata(wdata), .RW0_wmask(wmask),
      .RW0_rdata(rdata1), .RW0_rvalid(rvalid1), .RW0_ready(ready1),
      .init_req(init_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: memory contents, clear progress, and expected outputs.
   logic [31:0] mem_m [DEPTH];
   bit          ready_m;
   int          clr_m;
   logic [31:0] d0_m, d1_m;
   bit          v0_m, v1_m;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_eq("ready0", 32'(ready0), 32'(ready_m));
      check_eq("ready1", 32'(ready1), 32'(ready_m));
      check_eq("rvalid0", 32'(rvalid0), 32'(v0_m));
      check_eq("rdata0", rdata0, d0_m);
      check_eq("rvalid1", 32'(rvalid1), 32'(v1_m));
      check_eq("rdata1", rdata1, d1_m);
   endtask

   task automatic model_reset();
      ready_m = 0;
      clr_m   = 0;
      d0_m    = '0;
      d1_m    = '0;
      v0_m    = 0;
      v1_m    = 0;
   endtask

   // One rising edge with the currently driven inputs, then update model and compare.
   task automatic step();
      bit          v;
      logic [31:0] d;
      logic [31:0] m;
      v = 0;
      d = '0;
      @(posedge clk);
      #1;
      if (ready_m) begin
         if (en && wmode) begin
            m = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
            mem_m[addr] = (mem_m[addr] & ~m) | (wdata & m);
         end else if (en) begin
            v = 1;
            d = mem_m[addr];
         end
         if (init_req) begin
            ready_m = 0;
            clr_m   = 0;
         end
      end else begin
         mem_m[clr_m] = INIT;
         clr_m++;
         if (clr_m == DEPTH) ready_m = 1;
      end
      v1_m = v0_m;
      if (v0_m) d1_m = d0_m;
      v0_m = v;
      if (v) d0_m = d;
      check_outputs();
   endtask

   task automatic cyc(input bit e, input bit w, input logic [3:0] a, input logic [31:0] wd,
                      input logic [3:0] wm, input bit ir);
      en       = e;
      wmode    = w;
      addr     = a;
      wdata    = wd;
      wmask    = wm;
      init_req = ir;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0, 0);
   endtask

   // Asserts reset between edges, checks outputs clear at once, releases after two edges.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      model_reset();
      rst_n    = 1'b0;
      en       = 0;
      wmode    = 0;
      addr     = '0;
      wdata    = '0;
      wmask    = '0;
      init_req = 0;
      #1;
      check_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Initial clear with read attempts that must be ignored, then read every word.
      for (int i = 0; i < DEPTH; i++) cyc(i[0], 0, 4'(i), '0, '0, 0);
      check_eq("ready_after_clear", 32'(ready0), 32'd1);
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 4'(i), '0, '0, 0);
      idle(1);
      check_eq("init_word15", rdata0, INIT);

      // Masked write.
      cyc(1, 1, 4'd5, 32'h1122_3344, 4'hF, 0);
      cyc(1, 1, 4'd5, 32'hFFFF_FFFF, 4'b0101, 0);
      cyc(1, 0, 4'd5, '0, '0, 0);
      check_eq("masked_word", rdata0, 32'h11FF_33FF);
      cyc(1, 1, 4'd6, 32'h1234_5678, 4'h0, 0);
      cyc(1, 0, 4'd6, '0, '0, 0);
      idle(1);

      // Back-to-back reads, then a write must not disturb held data.
      cyc(1, 1, 4'd1, 32'h0000_0101, 4'hF, 0);
      cyc(1, 1, 4'd2, 32'h0000_0202, 4'hF, 0);
      cyc(1, 1, 4'd3, 32'h0000_0303, 4'hF, 0);
      cyc(1, 0, 4'd1, '0, '0, 0);
      cyc(1, 0, 4'd2, '0, '0, 0);
      cyc(1, 0, 4'd3, '0, '0, 0);
      cyc(1, 1, 4'd3, 32'hCAFE_F00D, 4'hF, 0);
      idle(3);
      check_eq("held_word3", rdata1, 32'h0000_0303);

      // Read concurrent with init_req completes; clear ignores en pulses.
      cyc(1, 1, 4'd7, 32'hDEAD_BEEF, 4'hF, 0);
      cyc(1, 0, 4'd7, '0, '0, 1);
      check_eq("read_with_init", rdata0, 32'hDEAD_BEEF);
      for (int i = 0; i < DEPTH; i++) cyc(1, $urandom_range(0, 1), 4'd7, $urandom, 4'hF, 1);
      cyc(1, 0, 4'd7, '0, '0, 0);
      idle(2);
      check_eq("word7_recleared", rdata1, INIT);

      // Reset during a read, then again at clear count 9.
      cyc(1, 1, 4'd9, 32'h5555_AAAA, 4'hF, 0);
      cyc(1, 0, 4'd9, '0, '0, 0);
      do_reset();
      idle(9);
      do_reset();
      idle(DEPTH);
      cyc(1, 0, 4'd9, '0, '0, 0);
      idle(2);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), 4'($urandom_range(0, DEPTH - 1)),
             $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 47) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_rw_init_ext.md
# sram_rw_init_ext

Parametrised single-port SRAM behavioural model, next generation of the fixed-size `_ext` array macros. Adds a configurable depth and width, and write masking at a configurable granularity. Adds an optional output pipeline stage, a read-valid strobe, and a hardware clear sequencer that initialises every word after reset or on request. It sits wherever generated memories instantiate an `_ext` array and need a known power-on state.

## Interface
Parameters:
- `DEPTH`, 1024: number of words; power of two, ≥ 2.
- `WIDTH`, 32: word width in bits.
- `MASK_GRAN`, 8: bits per write-mask lane; `WIDTH % MASK_GRAN == 0`.
- `OUT_REG`, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- `INIT_VAL`, 0: `WIDTH`-bit value written to every word by the clear sequencer.

Ports (AW = log2(DEPTH), MW = WIDTH/MASK_GRAN):
- `RW0_clk`  in  1  sole clock; all state updates on the rising edge.
- `RW0_rst_n`  in  1  asynchronous, active-low reset.
- `RW0_addr`  in  AW  word address.
- `RW0_en`  in  1  access request.
- `RW0_wmode`  in  1  1 = write, 0 = read.
- `RW0_wdata`  in  WIDTH  write data.
- `RW0_wmask`  in  MW  per-lane write enable; lane i covers bits [i*MASK_GRAN +: MASK_GRAN].
- `RW0_rdata`  out  WIDTH  read data.
- `RW0_rvalid`  out  1  one-cycle strobe marking new `RW0_rdata`.
- `RW0_ready`  out  1  1 = accesses accepted (sequencer idle).
- `init_req`  in  1  pulse requesting a full re-clear.

## Operation
- FSM has two states, CLEAR and IDLE. Reset forces CLEAR with the clear counter at 0.
- CLEAR:
  - Each cycle writes `INIT_VAL` to `ram[cnt]`, then increments `cnt`.
  - When `cnt == DEPTH-1` is written, the FSM moves to IDLE.
  - `RW0_ready = 0`. `RW0_en` is ignored: no write, no read, no `RW0_rvalid`. `init_req` is ignored.
- IDLE (`RW0_ready = 1`):
  - An access is accepted when `RW0_en` is high.
  - Write (`RW0_wmode = 1`): only lanes with `RW0_wmask[i] = 1` are updated. All-zero mask means no change.
  - Read (`RW0_wmode = 0`): `ram[RW0_addr]` is captured into the read-data register.
  - `init_req = 1` moves the FSM to CLEAR on the next edge with `cnt = 0`. An access presented in the same cycle is still accepted and completes normally, including its `RW0_rvalid`, because the clear's first write occurs one cycle later.
- Read data is held: `RW0_rdata` keeps the last read word until the next accepted read. Later writes, clears and idle cycles do not change it. This differs from the older macros, which re-index the array.
- With `OUT_REG = 1`, data and valid pass through one extra register stage. The stage advances every cycle; data updates only when the incoming valid is set.
- Address wrap: `cnt` reaching `DEPTH-1` ends the clear; it never wraps to 0 within one clear.
- `RW0_addr` is always in range, because its width is exactly log2(DEPTH).

## Timing
- Reset values: `RW0_rdata = 0`, `RW0_rvalid = 0`, `RW0_ready = 0`, FSM = CLEAR, `cnt = 0`, all pipeline registers 0.
- Memory contents are not reset directly. They are cleared by the sequencer.
- A clear takes exactly DEPTH cycles. `RW0_ready` rises on the edge after the write to word DEPTH-1. The same holds after `init_req`: the FSM enters CLEAR on the edge after `init_req`, then `RW0_ready` stays low for DEPTH cycles.
- Read latency is fixed and has no stall:
  - `OUT_REG = 0`: read accepted at edge N gives `RW0_rdata`/`RW0_rvalid` valid after edge N (visible in cycle N+1).
  - `OUT_REG = 1`: one cycle later.
- Back-to-back reads issue one per cycle; `RW0_rvalid` stays high on consecutive cycles.
- A read in the cycle after a write to the same address returns the new data.
- Reset asserted mid-clear or mid-read: outputs go to reset values immediately. Any in-flight `RW0_rvalid` is discarded, and the clear restarts from word 0 after release.

## Test plan
- Reset release, `DEPTH = 16`, `INIT_VAL = 32'hA5A5_A5A5` → `RW0_ready` low for 16 cycles, then high. Reading all 16 words returns `A5A5_A5A5` with `RW0_rvalid` after 1 cycle.
- Write `32'h1122_3344` to addr 5 with full mask, then write `32'hFFFF_FFFF` with mask `4'b0101` → reading addr 5 returns `32'h11FF_33FF`.
- `OUT_REG = 1`, reads of addrs 1, 2, 3 on consecutive cycles → `RW0_rvalid` high for 3 consecutive cycles starting 2 cycles after the first read, with data in order. `RW0_rdata` then holds word 3 after a later write to addr 3.
- Write `32'hDEAD_BEEF` to addr 7, then assert `init_req` together with a read of addr 7 → the read returns `DEAD_BEEF`, `RW0_ready` drops for 16 cycles, and a read of addr 7 afterward returns `INIT_VAL`. `RW0_en` pulses during the clear produce no `RW0_rvalid`.
- Assert `RW0_rst_n` low during a read and again at clear count 9 → outputs return to 0 immediately. After release, the clear runs a full 16 cycles from word 0.
